// File: rtl/alu_pkg.sv
// Shared ALU operation codes, FSM state encoding and op classification helpers.
// Imported by the ALU control decoder as well as by the execution-stage ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_SRA   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_XOR   = 4'b1010;
  localparam logic [3:0] OP_SLT_B = 4'b1011;
  localparam logic [3:0] OP_NE    = 4'b1110;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } alu_state_e;

  function automatic logic is_shift(input logic [3:0] op);
    case (op)
      OP_SLL, OP_SRL, OP_SRA: is_shift = 1'b1;
      default:                is_shift = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_comb_unit.sv
// Single-cycle ALU operations: logic, add/sub, compares and not-equal.
// Shift codes and unassigned codes fall through to ADD.
module alu_comb_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      aluop,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_diff;
  logic            w_lt_s;
  logic            w_lt_u;
  logic            w_ne;

  assign w_sum  = a + b;
  assign w_diff = a - b;
  assign w_lt_u = (a < b);
  assign w_lt_s = ($signed(a) < $signed(b));
  assign w_ne   = (a != b);

  // Operation select; compare results are zero-extended to XLEN.
  always_comb begin
    y = w_sum;
    case (aluop)
      OP_AND:           y = a & b;
      OP_OR:            y = a | b;
      OP_XOR:           y = a ^ b;
      OP_ADD:           y = w_sum;
      OP_SUB:           y = w_diff;
      OP_SLTU:          y = {{(XLEN-1){1'b0}}, w_lt_u};
      OP_SLT, OP_SLT_B: y = {{(XLEN-1){1'b0}}, w_lt_s};
      OP_NE:            y = {{(XLEN-1){1'b0}}, w_ne};
      default:          y = w_sum;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Execution-stage ALU: one-cycle ops via alu_comb_unit, shifts iterate one bit
// per cycle. Valid/ready on both sides; a single operation is in flight at a time.
module seq_alu
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      aluop,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam logic [SHW-1:0] CNT_ONE = SHW'(1'b1);

  alu_state_e      r_state;
  alu_state_e      w_next_state;
  logic [XLEN-1:0] r_shreg;
  logic [SHW-1:0]  r_count;
  logic [3:0]      r_op;
  logic [XLEN-1:0] r_result;
  logic            r_zero;

  logic            w_accept;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_comb_result;
  logic [XLEN-1:0] w_shift_next;
  logic            w_load_shift;
  logic            w_load_result;
  logic [XLEN-1:0] w_result_value;

  function automatic logic [XLEN-1:0] shift_one(input logic [3:0] op,
                                                input logic [XLEN-1:0] v);
    case (op)
      OP_SLL:  shift_one = {v[XLEN-2:0], 1'b0};
      OP_SRL:  shift_one = {1'b0, v[XLEN-1:1]};
      OP_SRA:  shift_one = {v[XLEN-1], v[XLEN-1:1]};
      default: shift_one = v;
    endcase
  endfunction

  alu_comb_unit #(
    .XLEN (XLEN)
  ) u_comb (
    .aluop (aluop),
    .a     (a),
    .b     (b),
    .y     (w_comb_result)
  );

  // in_ready is gated by reset so nothing is accepted on a reset cycle.
  assign in_ready     = (r_state == IDLE) && !reset;
  assign out_valid    = (r_state == DONE);
  assign result       = r_result;
  assign zero         = r_zero;
  assign w_accept     = in_valid && in_ready;
  assign w_shamt      = b[SHW-1:0];
  assign w_shift_next = shift_one(r_op, r_shreg);

  // Next-state and completion decode.
  always_comb begin
    w_next_state   = r_state;
    w_load_shift   = 1'b0;
    w_load_result  = 1'b0;
    w_result_value = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (is_shift(aluop)) begin
            if (w_shamt == '0) begin
              w_next_state   = DONE;
              w_load_result  = 1'b1;
              w_result_value = a;
            end else begin
              w_next_state = SHIFT;
              w_load_shift = 1'b1;
            end
          end else begin
            w_next_state   = DONE;
            w_load_result  = 1'b1;
            w_result_value = w_comb_result;
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      SHIFT: begin
        if (r_count == CNT_ONE) begin
          w_next_state   = DONE;
          w_load_result  = 1'b1;
          w_result_value = w_shift_next;
        end else begin
          w_next_state = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = DONE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Shift register, counter and output registers; reset drops any pending op.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg  <= '0;
      r_count  <= '0;
      r_op     <= OP_ADD;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else begin
      if (w_load_shift) begin
        r_shreg <= a;
        r_count <= w_shamt;
        r_op    <= aluop;
      end else if (r_state == SHIFT) begin
        r_shreg <= w_shift_next;
        r_count <= r_count - CNT_ONE;
      end
      if (w_load_result) begin
        r_result <= w_result_value;
        r_zero   <= (w_result_value == '0);
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: transaction-level reference model checked
// every cycle, plus directed vectors with hand-computed results and latencies.
module tb_seq_alu;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  aluop;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  seq_alu dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluop     (aluop),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [3:0] op, input logic [31:0] x,
                                            input logic [31:0] y);
    int sh;
    sh = int'(y[4:0]);
    case (op)
      4'b0000: model_res = x & y;
      4'b0001: model_res = x | y;
      4'b0011: model_res = 32'(x < y);
      4'b0100: model_res = 32'($signed(x) >>> sh);
      4'b0110: model_res = x - y;
      4'b0111: model_res = 32'($signed(x) < $signed(y));
      4'b1000: model_res = x << sh;
      4'b1001: model_res = x >> sh;
      4'b1010: model_res = x ^ y;
      4'b1011: model_res = 32'($signed(x) < $signed(y));
      4'b1110: model_res = 32'(x != y);
      default: model_res = x + y;
    endcase
  endfunction

  // Reference model: an accepted op completes after shamt cycles (shifts) or at once.
  int          m_phase = 0;  // 0 free, 1 working, 2 holding a result
  int          m_wait  = 0;
  logic [31:0] m_pend  = 32'd0;
  logic [31:0] m_res   = 32'd0;
  logic        m_zero  = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0;
      m_wait  = 0;
      m_res   = 32'd0;
      m_zero  = 1'b0;
    end else if (m_phase == 0) begin
      if (in_valid) begin
        m_pend = model_res(aluop, a, b);
        if ((aluop inside {4'b0100, 4'b1000, 4'b1001}) && (b[4:0] != 5'd0)) begin
          m_wait  = int'(b[4:0]);
          m_phase = 1;
        end else begin
          m_res   = m_pend;
          m_zero  = (m_pend == 32'd0);
          m_phase = 2;
        end
      end
    end else if (m_phase == 1) begin
      m_wait = m_wait - 1;
      if (m_wait == 0) begin
        m_res   = m_pend;
        m_zero  = (m_pend == 32'd0);
        m_phase = 2;
      end
    end else begin
      if (out_ready) m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc_in_ready", 32'(in_ready), 32'((m_phase == 0) && !reset));
      chk("cyc_out_valid", 32'(out_valid), 32'(m_phase == 2));
      chk("cyc_result", result, m_res);
      chk("cyc_zero", 32'(zero), 32'(m_zero));
    end
  end

  // Latency = clock edges from the accept edge to the edge that raises out_valid.
  task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_r,
                        input int exp_lat, input bit scramble);
    int lat;
    bit seen;
    aluop    = op;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    lat  = 0;
    seen = out_valid;
    while (!seen && lat < 200) begin
      if (scramble) begin
        a        = $urandom;
        b        = $urandom;
        aluop    = 4'($urandom);
        in_valid = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #2;
      lat++;
      seen = out_valid;
    end
    in_valid = 1'b0;
    chk({nm, "_done"}, 32'(seen), 32'd1);
    chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_res"}, result, exp_r);
    chk({nm, "_zero"}, 32'(zero), 32'(exp_r == 32'd0));
    if (out_ready) begin
      @(posedge clk); #2;
    end
  endtask

  initial begin
    bit saw;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    aluop     = 4'b0000;
    a         = 32'd0;
    b         = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    check_en = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    #1;

    run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0, 1'b0);
    run_op("sub",      4'b0110, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 0, 1'b0);
    run_op("slt",      4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 0, 1'b0);
    run_op("sltu",     4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0, 1'b0);
    run_op("slt_b",    4'b1011, 32'h0000_0003, 32'hFFFF_FFFE, 32'h0000_0000, 0, 1'b0);
    run_op("ne_eq",    4'b1110, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 0, 1'b0);
    run_op("ne_diff",  4'b1110, 32'h0000_1234, 32'h0000_1235, 32'h0000_0001, 0, 1'b0);
    run_op("op_1111",  4'b1111, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 0, 1'b0);
    run_op("and",      4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 0, 1'b0);
    run_op("or",       4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 0, 1'b0);
    run_op("sra31",    4'b0100, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 31, 1'b0);
    run_op("srl31",    4'b1001, 32'h8000_0000, 32'd31, 32'h0000_0001, 31, 1'b0);
    run_op("sra4_pos", 4'b0100, 32'h4000_0000, 32'd4, 32'h0400_0000, 4, 1'b0);
    run_op("sll0",     4'b1000, 32'h0000_0001, 32'd0, 32'h0000_0001, 0, 1'b0);
    run_op("sll_hib",  4'b1000, 32'h8000_0001, 32'h0000_0021, 32'h0000_0002, 1, 1'b0);

    // Backpressure: result held, nothing accepted while out_ready is low.
    out_ready = 1'b0;
    run_op("xor_bp", 4'b1010, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      chk("bp_result", result, 32'h0000_0FF0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #2;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    run_op("b2b", 4'b0101, 32'd10, 32'd20, 32'h0000_001E, 0, 1'b0);

    // Reset ten cycles into a 20-cycle shift.
    aluop    = 4'b1000;
    a        = 32'd1;
    b        = 32'd20;
    in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #2;
    end
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_result", result, 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    #1;
    saw = 1'b0;
    repeat (25) begin
      @(posedge clk); #2;
      saw = saw | out_valid;
    end
    chk("midrst_no_valid", 32'(saw), 32'd0);

    // Inputs toggled while a shift is in progress must not disturb it.
    run_op("srl_busy", 4'b1001, 32'hDEAD_BEEF, 32'd20, 32'h0000_0DEA, 20, 1'b1);
    run_op("after_busy", 4'b0010, 32'd7, 32'd8, 32'h0000_000F, 0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
